mmio_gpio: RTL

Parametrised memory-mapped GPIO peripheral for the RISC-V core's data-memory space. It generalises the fixed 16-switch/16-LED mapping to `GPIO_W` channels, and adds input synchronisation, debouncing, sticky change capture and a level interrupt. It sits behind DMem's address decode: DMem asserts `sel` for the GPIO window and forwards the store byte enables, write data and word offset.

---
 rtl/mmio_gpio.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: LED output register with set/clear/toggle aliases, synchronised
// and debounced switch inputs, sticky change flags and a registered level interrupt.

module mmio_gpio_deb #(
    parameter int DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic raw,
    output logic deb,
    output logic deb_nxt
);
    logic [3:0] cnt_q, cnt_d;
    logic       deb_q, deb_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (tick) begin
            if (raw == deb_q) begin
                cnt_d = 4'd0;
            end else if (cnt_q + 4'd1 == 4'(DEB_SAMPLES)) begin
                deb_d = raw;
                cnt_d = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 4'd0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb     = deb_q;
    assign deb_nxt = deb_d;
endmodule

module mmio_gpio #(
    parameter int GPIO_W      = 16,
    parameter int DEB_DIV     = 1000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sel,
    input  logic              rd,
    input  logic [3:0]        we,
    input  logic [2:0]        addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    input  logic [GPIO_W-1:0] sw,
    output logic [GPIO_W-1:0] led,
    output logic              irq
);
    localparam int          PW    = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DEB_DIV - 1);
    localparam logic [31:0] GMASK = (GPIO_W >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << GPIO_W) - 32'd1);

    localparam logic [2:0] A_LED  = 3'd0;
    localparam logic [2:0] A_SET  = 3'd1;
    localparam logic [2:0] A_CLR  = 3'd2;
    localparam logic [2:0] A_TGL  = 3'd3;
    localparam logic [2:0] A_RAW  = 3'd4;
    localparam logic [2:0] A_DEB  = 3'd5;
    localparam logic [2:0] A_EDGE = 3'd6;
    localparam logic [2:0] A_IEN  = 3'd7;

    logic [GPIO_W-1:0] sync1_q, raw_q;
    logic [PW-1:0]     pre_q, pre_d;
    logic              tick;
    logic [GPIO_W-1:0] deb_w, deb_nxt_w, chg;
    logic [31:0]       led_q, led_d;
    logic [GPIO_W-1:0] edge_q, edge_d;
    logic [GPIO_W-1:0] ien_q, ien_d;
    logic [31:0]       dout_q, dout_d;
    logic              irq_q, irq_d;
    logic              wr;
    logic [31:0]       wm, wd;
    logic [31:0]       rdata;

    assign tick  = (pre_q == PMAX);
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    for (genvar i = 0; i < GPIO_W; i++) begin : g_lane
        mmio_gpio_deb #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk     (clk),
            .rstn    (rstn),
            .tick    (tick),
            .raw     (raw_q[i]),
            .deb     (deb_w[i]),
            .deb_nxt (deb_nxt_w[i])
        );
    end

    // Flags are raised on the same edge the debounced value moves.
    assign chg = deb_nxt_w ^ deb_w;

    assign wr = sel && (|we);
    assign wm = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    assign wd = data_in & wm & GMASK;

    always_comb begin
        led_d  = led_q;
        ien_d  = ien_q;
        edge_d = edge_q;
        if (wr) begin
            case (addr)
                A_LED:   led_d = (led_q & ~wm) | wd;
                A_SET:   led_d = led_q | wd;
                A_CLR:   led_d = led_q & ~wd;
                A_TGL:   led_d = led_q ^ wd;
                A_EDGE:  edge_d = edge_q & ~wd[GPIO_W-1:0];
                A_IEN:   ien_d = (ien_q & ~wm[GPIO_W-1:0]) | wd[GPIO_W-1:0];
                default: ;
            endcase
        end
        // Hardware set overrides a same-cycle software clear.
        edge_d = edge_d | chg;
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            A_LED:   rdata = led_q;
            A_RAW:   rdata = 32'(raw_q);
            A_DEB:   rdata = 32'(deb_w);
            A_EDGE:  rdata = 32'(edge_q);
            A_IEN:   rdata = 32'(ien_q);
            default: rdata = 32'd0;
        endcase
        dout_d = (sel && rd) ? rdata : dout_q;
        irq_d  = |(edge_q & ien_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            raw_q   <= '0;
            pre_q   <= '0;
            led_q   <= 32'd0;
            edge_q  <= '0;
            ien_q   <= '0;
            dout_q  <= 32'd0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= sw;
            raw_q   <= sync1_q;
            pre_q   <= pre_d;
            led_q   <= led_d;
            edge_q  <= edge_d;
            ien_q   <= ien_d;
            dout_q  <= dout_d;
            irq_q   <= irq_d;
        end
    end

    assign led      = led_q[GPIO_W-1:0];
    assign data_out = dout_q;
    assign irq      = irq_q;
endmodule
